// File: rtl/mux_arb_nto1_if.sv
// Bus bundle for mux_arb_nto1: N packed input channels plus one output channel.
// Ports: in_data/in_valid/in_ready (N producers), out_data/out_sel/out_valid/out_ready (consumer).
// The slave modport is the multiplexer's view; master is the producer/consumer side.
interface mux_arb_nto1_if #(
  parameter int WIDTH = 24,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N:1 word multiplexer with one registered output stage; direct-select or round-robin grant.
// Ports: Clock, Reset (async, active-high), Mode (0 direct / 1 round-robin), Selector, bus (slave).
// Latency 1 cycle; full throughput with out_ready high; in_ready is combinational from
// out_valid/out_ready and the grant, and is held low whenever the output word is stalled.
module mux_arb_nto1 #(
  parameter  int WIDTH = 24,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Mode,
  input  logic [SELW-1:0] Selector,
  mux_arb_nto1_if.slave   bus
);

  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic             out_valid_q;
  logic [SELW-1:0]  rr_ptr;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [N-1:0]     in_ready_c;
  logic [WIDTH-1:0] gnt_word;

  // The output register can take a new word when empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // Grant: at most one channel. Direct mode looks only at the selected channel's
  // valid, so other channels have no combinational influence on its ready.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!Mode) begin
      for (int k = 0; k < N; k++) begin
        if (Selector == SELW'(k) && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end else begin
      // Search starts one past the last round-robin winner and wraps modulo N;
      // the first valid channel found in that order wins.
      for (int i = 1; i <= N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (!gnt_vld && k == (int'(rr_ptr) + i) % N && bus.in_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(k);
          end
        end
      end
    end
  end

  // Ready goes only to the granted channel, and never while reset is asserted.
  always_comb begin
    in_ready_c = '0;
    gnt_word   = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_vld && gnt_idx == SELW'(k)) begin
        in_ready_c[k] = load_en && !Reset;
        gnt_word      = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= SELW'(N - 1);
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_word;
        out_sel_q   <= gnt_idx;
        // Only round-robin wins move the fairness pointer.
        if (Mode) begin
          rr_ptr <= gnt_idx;
        end
      end else begin
        // Drained with nothing new: data/sel keep the last word for observability.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule
